// File: rtl/ctrl_sequencer_if.sv
// Bus bundle between the control sequencer and the datapath blocks it
// drives: instruction register, register file and ALU. The sequencer side
// uses the master modport; the datapath (or a bench model of it) uses slave.
interface ctrl_sequencer_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
);

  // Instruction register side
  logic [PC_W-1:0]   pc;
  logic              ir_en;
  logic [15:0]       ir_data;

  // Register file side
  logic [1:0]        reg_addr;
  logic              reg_rd;
  logic              reg_wr;
  logic [DATA_W-1:0] reg_din;
  logic [DATA_W-1:0] reg_dout;

  // ALU side
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_out;

  modport master (
    output pc, ir_en, reg_addr, reg_rd, reg_wr, reg_din, alu_op, alu_a, alu_b,
    input  ir_data, reg_dout, alu_out
  );

  modport slave (
    input  pc, ir_en, reg_addr, reg_rd, reg_wr, reg_din, alu_op, alu_a, alu_b,
    output ir_data, reg_dout, alu_out
  );

endinterface

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute controller for the 8-bit processor.
// Runs a fixed-length program from the instruction register, reading
// operands from the register file, issuing ALU operations and writing
// results back. Supports LOAD-immediate, ADD, SUB and HALT; every other
// opcode retires as a NOP.
module ctrl_sequencer #(
  parameter int PC_W     = 8,
  parameter int DATA_W   = 8,
  parameter int PROG_LEN = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  ctrl_sequencer_if.master bus,
  output logic             busy,
  output logic             halted,
  output logic             instr_done
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  // One bit wider than pc so that PROG_LEN == 2**PC_W is still reachable
  // and the sequencer halts instead of wrapping back to address 0.
  localparam logic [PC_W:0] PC_END = (PC_W + 1)'(PROG_LEN);

  typedef enum logic [1:0] {
    K_LOAD,
    K_ARITH,
    K_HALT,
    K_NOP
  } kind_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  function automatic kind_t classify(input logic [3:0] op);
    case (op)
      OP_LOAD:        return K_LOAD;
      OP_ADD, OP_SUB: return K_ARITH;
      OP_HALT:        return K_HALT;
      default:        return K_NOP;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;

  logic [PC_W:0]     pc_inc;
  logic              retire;

  logic              ir_en;
  logic [1:0]        reg_addr;
  logic              reg_rd;
  logic              reg_wr;
  logic [DATA_W-1:0] reg_din;

  // Instruction fields, taken from the latched IR once DECODE is over.
  logic [3:0]        ir_op;
  logic [1:0]        ir_dst;
  logic [1:0]        ir_src_a;
  logic [1:0]        ir_src_b;
  logic [7:0]        ir_imm;
  logic              unused_ir_bits;

  assign ir_op          = ir_q[15:12];
  assign ir_dst         = ir_q[9:8];
  assign ir_src_a       = ir_q[5:4];
  assign ir_src_b       = ir_q[1:0];
  assign ir_imm         = ir_q[7:0];
  assign unused_ir_bits = ^ir_q[11:10];

  assign pc_inc = {1'b0, pc_q} + (PC_W + 1)'(1);

  // State, program counter, IR and ALU operand registers.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
    end
  end

  // Next-state, register updates and bus strobes for each sequencer state.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    ir_en    = 1'b0;
    reg_addr = '0;
    reg_rd   = 1'b0;
    reg_wr   = 1'b0;
    reg_din  = '0;
    retire   = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        ir_en   = 1'b1;
        state_d = S_DECODE;
      end

      // The instruction word arrives this cycle; branch on it directly so a
      // NOP can retire without spending an extra cycle on the latched copy.
      S_DECODE: begin
        ir_en = 1'b1;
        ir_d  = bus.ir_data;
        case (classify(bus.ir_data[15:12]))
          K_LOAD:  state_d = S_WB;
          K_ARITH: state_d = S_RD_A;
          K_HALT:  state_d = S_HALT;
          default: retire  = 1'b1;
        endcase
      end

      S_RD_A: begin
        reg_addr = ir_src_a;
        reg_rd   = 1'b1;
        state_d  = S_RD_B;
      end

      // Operand A (requested in RD_A) is on reg_dout now.
      S_RD_B: begin
        alu_a_d  = bus.reg_dout;
        reg_addr = ir_src_b;
        reg_rd   = 1'b1;
        state_d  = S_EXEC;
      end

      // Operand B (requested in RD_B) is on reg_dout now. Both operands are
      // captured before WB, so dst may alias either source.
      S_EXEC: begin
        alu_b_d  = bus.reg_dout;
        alu_op_d = (ir_op == OP_SUB) ? ALU_SUB : ALU_ADD;
        state_d  = S_WB;
      end

      S_WB: begin
        reg_wr   = 1'b1;
        reg_addr = ir_dst;
        reg_din  = (classify(ir_op) == K_LOAD) ? DATA_W'(ir_imm) : bus.alu_out;
        retire   = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // Retirement is shared by WB and the NOP branch of DECODE. start is not
    // looked at here, so a start arriving with the final retire is dropped.
    instr_done = retire;
    if (retire) begin
      pc_d    = pc_inc[PC_W-1:0];
      state_d = (pc_inc == PC_END) ? S_HALT : S_FETCH;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.ir_en    = ir_en;
  assign bus.reg_addr = reg_addr;
  assign bus.reg_rd   = reg_rd;
  assign bus.reg_wr   = reg_wr;
  assign bus.reg_din  = reg_din;
  assign bus.alu_op   = alu_op_q;
  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;

  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: datapath models on the slave side of the bus,
// an instruction-level reference model that expands each program into the
// expected per-cycle bus activity, and a compare process on the falling edge.
module tb_ctrl_sequencer;

  localparam int PC_W     = 3;
  localparam int DATA_W   = 8;
  localparam int PROG_LEN = 8;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic halted;
  logic instr_done;

  ctrl_sequencer_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

  ctrl_sequencer #(.PC_W(PC_W), .DATA_W(DATA_W), .PROG_LEN(PROG_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .halted     (halted),
    .instr_done (instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- datapath models (one-cycle read latency) ----------------
  logic [15:0] prog [PROG_LEN];
  logic [7:0]  rf [4] = '{default: 8'h00};
  logic [15:0] ir_data_q = 16'h0000;
  logic [7:0]  dout_q = 8'h00;

  always @(posedge clk) begin
    if (bus.ir_en)  ir_data_q <= prog[bus.pc];
    if (bus.reg_rd) dout_q <= rf[bus.reg_addr];
    if (bus.reg_wr) rf[bus.reg_addr] <= bus.reg_din;
  end

  assign bus.ir_data  = ir_data_q;
  assign bus.reg_dout = dout_q;
  assign bus.alu_out  = (bus.alu_op == 3'b001) ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;

  // ---------------- reference model ----------------
  typedef struct {
    logic [PC_W-1:0] pc;
    bit              ir_en;
    bit              rd;
    bit              wr;
    bit              done;
    logic [1:0]      addr;
    logic [7:0]      din;
    logic [7:0]      a;
    logic [7:0]      b;
    logic [2:0]      op;
  } exp_t;

  exp_t            exp_q[$];
  logic [7:0]      m_regs [4] = '{default: 8'h00};
  logic [7:0]      m_a = 0, m_b = 0;
  logic [2:0]      m_op = 0;
  logic [PC_W-1:0] m_pc = 0, fin_pc = 0;
  bit              m_halted = 0;

  function automatic exp_t mk(int pc, bit ir_en, bit rd, bit wr, bit done,
                              logic [1:0] addr, logic [7:0] din,
                              logic [7:0] a, logic [7:0] b, logic [2:0] op);
    exp_t e;
    e.pc = PC_W'(pc); e.ir_en = ir_en; e.rd = rd; e.wr = wr; e.done = done;
    e.addr = addr; e.din = din; e.a = a; e.b = b; e.op = op;
    return e;
  endfunction

  // Execute the program at instruction level and list what the bus must show
  // on each cycle: FETCH+DECODE for every instruction, then 1 write cycle for
  // LOAD, 2 reads + 1 execute + 1 write for ADD/SUB, nothing more for NOP.
  function automatic void build_trace();
    logic [7:0]  r [4];
    logic [7:0]  a, b, res;
    logic [2:0]  op;
    logic [15:0] ins;
    logic [1:0]  dst, sa, sb;
    r = m_regs; a = m_a; b = m_b; op = m_op;
    for (int p = 0; p < PROG_LEN; p++) begin
      ins = prog[p];
      dst = ins[9:8]; sa = ins[5:4]; sb = ins[1:0];
      exp_q.push_back(mk(p, 1, 0, 0, 0, 0, 0, a, b, op));
      case (ins[15:12])
        4'h8: begin
          exp_q.push_back(mk(p, 1, 0, 0, 0, 0, 0, a, b, op));
          exp_q.push_back(mk(p, 0, 0, 1, 1, dst, ins[7:0], a, b, op));
          r[dst] = ins[7:0];
        end
        4'h0, 4'h1: begin
          exp_q.push_back(mk(p, 1, 0, 0, 0, 0, 0, a, b, op));
          exp_q.push_back(mk(p, 0, 1, 0, 0, sa, 0, a, b, op));
          exp_q.push_back(mk(p, 0, 1, 0, 0, sb, 0, a, b, op));
          a = r[sa];
          exp_q.push_back(mk(p, 0, 0, 0, 0, 0, 0, a, b, op));
          b   = r[sb];
          op  = (ins[15:12] == 4'h1) ? 3'b001 : 3'b000;
          res = (op == 3'b001) ? a - b : a + b;
          exp_q.push_back(mk(p, 0, 0, 1, 1, dst, res, a, b, op));
          r[dst] = res;
        end
        4'hF: begin
          exp_q.push_back(mk(p, 1, 0, 0, 0, 0, 0, a, b, op));
          fin_pc = PC_W'(p);
          return;
        end
        default: exp_q.push_back(mk(p, 1, 0, 0, 1, 0, 0, a, b, op));
      endcase
    end
    fin_pc = PC_W'(PROG_LEN);
  endfunction

  // Advance the model one cycle per rising edge; reset wipes pending work.
  initial forever begin
    exp_t e;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      m_halted = 0; m_pc = 0; m_a = 0; m_b = 0; m_op = 0;
    end else if (exp_q.size() == 0) begin
      if (start) begin
        m_halted = 0;
        build_trace();
      end
    end else begin
      e = exp_q.pop_front();
      m_a = e.a; m_b = e.b; m_op = e.op;
      if (e.wr) m_regs[e.addr] = e.din;
      if (exp_q.size() == 0) begin
        m_halted = 1;
        m_pc     = fin_pc;
      end
    end
  end

  // ---------------- compare process and event counters ----------------
  int         busy_total = 0, done_total = 0, wr_total = 0, rd_total = 0;
  int         done_idx[$];
  int         wr_idx[$];
  logic [7:0] last_wr_a = 0, last_wr_b = 0;

  initial forever begin
    exp_t e;
    bit   eb, eh;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q[0]; eb = 1; eh = 0;
    end else begin
      e = mk(int'(m_pc), 0, 0, 0, 0, 0, 0, m_a, m_b, m_op); eb = 0; eh = m_halted;
    end
    check("busy", busy, eb);
    check("halted", halted, eh);
    check("pc", bus.pc, e.pc);
    check("ir_en", bus.ir_en, e.ir_en);
    check("reg_rd", bus.reg_rd, e.rd);
    check("reg_wr", bus.reg_wr, e.wr);
    check("instr_done", instr_done, e.done);
    check("alu_a", bus.alu_a, e.a);
    check("alu_b", bus.alu_b, e.b);
    check("alu_op", bus.alu_op, e.op);
    if (e.rd || e.wr) check("reg_addr", bus.reg_addr, e.addr);
    if (e.wr)         check("reg_din", bus.reg_din, e.din);

    if (busy) busy_total++;
    if (instr_done) begin done_total++; done_idx.push_back(busy_total); end
    if (bus.reg_rd) rd_total++;
    if (bus.reg_wr) begin
      wr_total++;
      wr_idx.push_back(busy_total);
      last_wr_a = bus.alu_a;
      last_wr_b = bus.alu_b;
    end
  end

  // ---------------- stimulus helpers ----------------
  int b0, d0, w0, r0;

  task automatic snapshot();
    b0 = busy_total; d0 = done_total; w0 = wr_total; r0 = rd_total;
  endtask

  task automatic load_prog(input logic [15:0] p [PROG_LEN]);
    for (int i = 0; i < PROG_LEN; i++) prog[i] = p[i];
  endtask

  // Pulse start, then wait (bounded) for HALT; optionally fire stray start
  // pulses while the program runs, all of which must be ignored.
  task automatic run_prog(input bit noisy);
    bit reached = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (halted) begin
        reached = 1;
        break;
      end
      start = noisy && ($urandom_range(0, 5) == 0);
    end
    start = 1'b0;
    check("halt_reached", reached, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_done"}, instr_done, 0);
    check({tag, "_pc"}, bus.pc, 0);
    check({tag, "_ir_en"}, bus.ir_en, 0);
    check({tag, "_rd"}, bus.reg_rd, 0);
    check({tag, "_wr"}, bus.reg_wr, 0);
    check({tag, "_addr"}, bus.reg_addr, 0);
    check({tag, "_din"}, bus.reg_din, 0);
    check({tag, "_alu_op"}, bus.alu_op, 0);
    check({tag, "_alu_a"}, bus.alu_a, 0);
    check({tag, "_alu_b"}, bus.alu_b, 0);
  endtask

  function automatic logic [15:0] rand_ins();
    logic [15:0] ins;
    logic [3:0]  op;
    int          k;
    ins = 16'($urandom);
    k   = $urandom_range(0, 11);
    if (k < 4)       op = 4'h8;
    else if (k < 7)  op = 4'h0;
    else if (k < 10) op = 4'h1;
    else if (k == 11 && $urandom_range(0, 1) == 1) op = 4'hF;
    else begin
      op = 4'($urandom_range(2, 13));
      if (op >= 4'h8) op = op + 4'h1;
    end
    ins[15:12] = op;
    return ins;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] p [PROG_LEN];
    logic [7:0]  rf3_before;
    int          wr_before, rds;

    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < PROG_LEN; i++) prog[i] = 16'hF000;

    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Reference program, with stray start pulses while busy.
    p = '{16'h8105, 16'h8203, 16'h0312, 16'h1021, 16'hF000, 16'hF000, 16'hF000, 16'hF000};
    load_prog(p);
    snapshot();
    run_prog(1);
    check("main_cycles", busy_total - b0, 20);
    check("main_done_cnt", done_total - d0, 4);
    check("main_wr_cnt", wr_total - w0, 4);
    check("main_pc", bus.pc, 4);
    check("main_halted", halted, 1);
    check("main_r0", rf[0], 8'hFE);
    check("main_r1", rf[1], 8'h05);
    check("main_r2", rf[2], 8'h03);
    check("main_r3", rf[3], 8'h08);

    // Restart from HALT re-executes with identical results.
    snapshot();
    run_prog(0);
    check("rerun_done_cnt", done_total - d0, 4);
    check("rerun_r0", rf[0], 8'hFE);
    check("rerun_r3", rf[3], 8'h08);

    // Single LOAD: write lands in cycle 3, no reads at all.
    p = '{16'h8105, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000};
    load_prog(p);
    snapshot();
    run_prog(0);
    check("load_wr_cycle", wr_idx[w0] - b0, 3);
    check("load_wr_cnt", wr_total - w0, 1);
    check("load_rd_cnt", rd_total - r0, 0);
    check("load_r1", rf[1], 8'h05);

    // dst aliases both sources.
    p = '{16'h8105, 16'h0111, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000};
    load_prog(p);
    run_prog(0);
    check("alias_r1", rf[1], 8'h0A);
    check("alias_wb_a", last_wr_a, 8'h05);
    check("alias_wb_b", last_wr_b, 8'h05);

    // No HALT opcode: stops after the last address, pc wraps to 0.
    p = '{16'h5000, 16'h8107, 16'h2000, 16'h3000, 16'h4000, 16'h6000, 16'h7000, 16'h9000};
    load_prog(p);
    snapshot();
    run_prog(0);
    check("nop_first_done", done_idx[d0] - b0, 2);
    check("nop_cycles", busy_total - b0, 17);
    check("nop_done_cnt", done_total - d0, 8);
    check("nop_r1", rf[1], 8'h07);
    check("nop_pc", bus.pc, 0);
    check("nop_halted", halted, 1);

    // Reset while the second operand read of an ADD is on the bus.
    p = '{16'h0312, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000};
    load_prog(p);
    rf3_before = rf[3];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rds = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.reg_rd) rds++;
      if (rds == 2) break;
    end
    check("rdb_reached", rds, 2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    wr_before = wr_total;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("midreset_no_wr", wr_total - wr_before, 0);
    check("midreset_r3", rf[3], rf3_before);
    check("midreset_idle", busy, 0);

    // Randomized programs, stray start pulses included.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < PROG_LEN; i++) p[i] = rand_ins();
      load_prog(p);
      run_prog(1);
    end
    for (int i = 0; i < 4; i++) check($sformatf("final_r%0d", i), rf[i], m_regs[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Hardware fetch/decode/execute controller for the 8-bit processor.
- Drives `inst_reg` (`pc`, `en`), `registers` (`addr`, `rd`, `wr`, `data_in`) and `alu` (`opcode`, `A`, `B`).
- Consumes `ir_data`, `data_out` and `alu_out`, and replaces bench-driven sequencing with a synthesizable FSM.
- Executes LOAD-immediate, ADD, SUB, HALT; any other opcode executes as NOP.

Parameters:
- PC_W, 8: program counter width.
- DATA_W, 8: datapath width.
- PROG_LEN, 5: number of instructions; sequencer halts after the instruction at `pc = PROG_LEN-1` retires.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins execution from pc=0 when in IDLE or HALT
- pc  output  PC_W  instruction address to inst_reg
- ir_en  output  1  instruction read enable to inst_reg
- ir_data  input  16  instruction word from inst_reg
- reg_addr  output  2  register file address
- reg_rd  output  1  register read strobe
- reg_wr  output  1  register write strobe
- reg_din  output  DATA_W  register write data
- reg_dout  input  DATA_W  register read data
- alu_op  output  3  ALU opcode (000 add, 001 sub)
- alu_a  output  DATA_W  ALU operand A (registered)
- alu_b  output  DATA_W  ALU operand B (registered)
- alu_out  input  DATA_W  ALU result
- busy  output  1  high in every state except IDLE and HALT
- halted  output  1  high in HALT
- instr_done  output  1  one-cycle pulse when an instruction retires

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0, including pc, strobes, alu_op, alu_a, alu_b, busy, halted, instr_done.
  - The internal IR clears to 0.
  - Reset mid-instruction abandons it: no partial write completes after reset asserts.
- Instruction decode fields:
  - op = IR[15:12], dst = IR[9:8], srcA = IR[5:4], srcB = IR[1:0], imm = IR[7:0].
  - op 1000 = LOAD, 0000 = ADD, 0001 = SUB, 1111 = HALT, all others = NOP.
- Interface latency: `inst_reg` and `registers` return data the cycle after the request is driven. The sequencer samples that data at the end of the following state.
- States:
  - IDLE: strobes low. start=1 → pc<=0, go to FETCH.
  - FETCH: ir_en=1, pc driven → DECODE.
  - DECODE: ir_en=1; IR<=ir_data at cycle end. Next state follows the decoded opcode:
    - LOAD → WB.
    - ADD or SUB → RD_A.
    - HALT → HALT, with no pc increment and no instr_done.
    - NOP → RETIRE path: pc<=pc+1, instr_done=1, then FETCH or HALT.
  - RD_A: reg_addr=srcA, reg_rd=1 → RD_B.
  - RD_B: alu_a<=reg_dout; reg_addr=srcB, reg_rd=1 → EXEC.
  - EXEC: alu_b<=reg_dout; alu_op<=000 (ADD) or 001 (SUB) → WB.
  - WB: reg_wr=1, reg_addr=dst, reg_din=imm (LOAD) or alu_out (ADD/SUB). Retire: pc<=pc+1, instr_done=1. Then HALT if pc+1 == PROG_LEN, else FETCH.
  - HALT: halted=1, busy=0, strobes low, pc held. start=1 → pc<=0, halted<=0, go to FETCH.
- Strobe rules:
  - reg_rd and reg_wr are never high in the same cycle.
  - reg_wr is high for exactly one cycle per LOAD/ADD/SUB.
- Cycle counts from the FETCH cycle:
  - LOAD: 3 cycles.
  - ADD/SUB: 6 cycles.
  - NOP: 2 cycles.
  - HALT: 2 cycles, then HALT state.
- Arithmetic: ALU result is mod 2^DATA_W (SUB wraps, e.g. 3-5 = 254). The sequencer does not alter alu_out.
- Boundaries:
  - The pc+1 comparison uses PC_W+1 bits, so PROG_LEN = 2^PC_W halts after the last address instead of wrapping.
  - start while busy is ignored.
  - start in the same cycle as the final retire is ignored; HALT is entered first.
  - dst equal to srcA or srcB is legal; operands are captured before WB.
  - alu_op, alu_a and alu_b hold their last values outside EXEC/WB.

Test Plan:
- Reset: assert rst_n=0 mid-ADD (during RD_B) → all outputs 0 immediately, state IDLE; no reg_wr afterwards until start.
- Program 8105, 8203, 0312, 1021, F000 with start → R1=5, R2=3, R3=8, R0=254 (0xFE).
  - Expected: halted=1 with pc=4; exactly 4 instr_done pulses; 4 reg_wr pulses.
  - Total 3+3+6+6+2 = 20 cycles from first FETCH to HALT entry.
- Load cycle check: single 8105 → reg_wr high only in cycle 3 with reg_addr=1, reg_din=5; reg_rd never high.
- NOP plus PROG_LEN end: program 5000, 8107 with PROG_LEN=2 → first instr_done after 2 cycles, R1=7, halted=1 at pc=2 without any HALT opcode.
- Restart and ignored start: pulse start during busy → no effect. Pulse start in HALT → pc=0, program re-executes with identical register results.
- Aliasing: R1=5, then 0111 (R1=R1+R1) → R1=10; alu_a=alu_b=5 in WB.
